// File: rtl/vram_arbiter_if.sv
// VRAM a-port arbitration bundle: CPU and DMA requesters,
// vblank gating and the registered VRAM a-port.
interface vram_arbiter_if;
  logic        cpu_req;
  logic [12:0] cpu_addr;
  logic [31:0] cpu_wrdata;
  logic [7:0]  cpu_wrsel;
  logic        cpu_wren;
  logic        cpu_ack;
  logic [31:0] cpu_rddata;
  logic        cpu_rdvalid;

  logic        dma_req;
  logic [12:0] dma_addr;
  logic [31:0] dma_wrdata;
  logic [7:0]  dma_wrsel;
  logic        dma_wren;
  logic        dma_ack;
  logic [31:0] dma_rddata;
  logic        dma_rdvalid;

  logic        dma_vblank_only;
  logic        vblank;

  logic [12:0] vram_addr;
  logic [31:0] vram_wrdata;
  logic [7:0]  vram_wrsel;
  logic        vram_wren;
  logic [31:0] vram_rddata;

  modport slave (
    input  cpu_req, cpu_addr, cpu_wrdata,
    input  cpu_wrsel, cpu_wren,
    output cpu_ack, cpu_rddata, cpu_rdvalid,
    input  dma_req, dma_addr, dma_wrdata,
    input  dma_wrsel, dma_wren,
    output dma_ack, dma_rddata, dma_rdvalid,
    input  dma_vblank_only, vblank,
    output vram_addr, vram_wrdata,
    output vram_wrsel, vram_wren,
    input  vram_rddata
  );

  modport master (
    output cpu_req, cpu_addr, cpu_wrdata,
    output cpu_wrsel, cpu_wren,
    input  cpu_ack, cpu_rddata, cpu_rdvalid,
    output dma_req, dma_addr, dma_wrdata,
    output dma_wrsel, dma_wren,
    input  dma_ack, dma_rddata, dma_rdvalid,
    output dma_vblank_only, vblank,
    input  vram_addr, vram_wrdata,
    input  vram_wrsel, vram_wren,
    output vram_rddata
  );
endinterface

// File: rtl/vram_arbiter.sv
// CPU/DMA arbiter for the VRAM a-port: fixed CPU priority,
// DMA starvation guard, optional vblank-only DMA.
module vram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  vram_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic        run_q;
  logic [3:0]  starve_q, starve_d;
  logic [12:0] addr_q, addr_d;
  logic [31:0] wrdata_q, wrdata_d;
  logic [7:0]  wrsel_q, wrsel_d;
  logic        wren_q, wren_d;
  logic        rd_v1_q, rd_v1_d;
  logic        rd_own_q, rd_own_d;
  logic        cpu_rdv_q, cpu_rdv_d;
  logic        dma_rdv_q, dma_rdv_d;

  logic dma_elig;
  logic starve_hit;
  logic cpu_gnt;
  logic dma_gnt;

  always_comb begin
    dma_elig   = bus.dma_req &&
                 (!bus.dma_vblank_only || bus.vblank);
    starve_hit = (starve_q == LIMIT) && dma_elig;
    cpu_gnt    = run_q && bus.cpu_req && !starve_hit;
    dma_gnt    = run_q && dma_elig &&
                 (starve_hit || !bus.cpu_req);
  end

  always_comb begin
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    wrsel_d  = wrsel_q;
    wren_d   = 1'b0;
    rd_v1_d  = 1'b0;
    rd_own_d = rd_own_q;
    unique case (1'b1)
      cpu_gnt: begin
        addr_d   = bus.cpu_addr;
        wrdata_d = bus.cpu_wrdata;
        wrsel_d  = bus.cpu_wrsel;
        wren_d   = bus.cpu_wren;
        rd_v1_d  = !bus.cpu_wren;
        rd_own_d = 1'b0;
      end
      dma_gnt: begin
        addr_d   = bus.dma_addr;
        wrdata_d = bus.dma_wrdata;
        wrsel_d  = bus.dma_wrsel;
        wren_d   = bus.dma_wren;
        rd_v1_d  = !bus.dma_wren;
        rd_own_d = 1'b1;
      end
      default: ;
    endcase
  end

  // owner stage: rdvalid lands with the VRAM's registered read data
  always_comb begin
    cpu_rdv_d = rd_v1_q && !rd_own_q;
    dma_rdv_d = rd_v1_q && rd_own_q;
  end

  always_comb begin
    starve_d = starve_q;
    if (!run_q || !dma_elig || dma_gnt)
      starve_d = '0;
    else if (starve_q < LIMIT)
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q     <= 1'b0;
      starve_q  <= '0;
      addr_q    <= '0;
      wrdata_q  <= '0;
      wrsel_q   <= '0;
      wren_q    <= 1'b0;
      rd_v1_q   <= 1'b0;
      rd_own_q  <= 1'b0;
      cpu_rdv_q <= 1'b0;
      dma_rdv_q <= 1'b0;
    end else begin
      run_q     <= 1'b1;
      starve_q  <= starve_d;
      addr_q    <= addr_d;
      wrdata_q  <= wrdata_d;
      wrsel_q   <= wrsel_d;
      wren_q    <= wren_d;
      rd_v1_q   <= rd_v1_d;
      rd_own_q  <= rd_own_d;
      cpu_rdv_q <= cpu_rdv_d;
      dma_rdv_q <= dma_rdv_d;
    end
  end

  assign bus.cpu_ack     = cpu_gnt;
  assign bus.dma_ack     = dma_gnt;
  assign bus.cpu_rddata  = bus.vram_rddata;
  assign bus.dma_rddata  = bus.vram_rddata;
  assign bus.cpu_rdvalid = cpu_rdv_q;
  assign bus.dma_rdvalid = dma_rdv_q;
  assign bus.vram_addr   = addr_q;
  assign bus.vram_wrdata = wrdata_q;
  assign bus.vram_wrsel  = wrsel_q;
  assign bus.vram_wren   = wren_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a VRAM read model
// returning DEAD0000|addr one cycle after the address.
module tb_vram_arbiter;

  logic clk;
  logic reset;
  int   nchk;
  int   nerr;

  vram_arbiter_if bus ();

  vram_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    bus.vram_rddata <= 32'hDEAD0000 | {19'h0, bus.vram_addr};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
  endtask

  task automatic cpu_set(input logic [12:0] a,
                         input logic [31:0] d,
                         input logic w);
    bus.cpu_req    = 1'b1;
    bus.cpu_addr   = a;
    bus.cpu_wrdata = d;
    bus.cpu_wrsel  = 8'h0F;
    bus.cpu_wren   = w;
  endtask

  task automatic dma_set(input logic [12:0] a,
                         input logic [31:0] d,
                         input logic [7:0] s,
                         input logic w);
    bus.dma_req    = 1'b1;
    bus.dma_addr   = a;
    bus.dma_wrdata = d;
    bus.dma_wrsel  = s;
    bus.dma_wren   = w;
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    reset = 1'b0;
    bus.vram_rddata = '0;
    bus.dma_vblank_only = 1'b0;
    bus.vblank = 1'b0;
    cpu_set(13'h0, 32'h0, 1'b0);
    dma_set(13'h0, 32'h0, 8'h0, 1'b0);
    idle();

    // reset state, with a request held during reset
    tick();
    bus.cpu_req = 1'b1;
    #2;
    check("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    check("rst_addr", 32'(bus.vram_addr), 32'd0);
    check("rst_wren", 32'(bus.vram_wren), 32'd0);
    check("rst_wrdata", bus.vram_wrdata, 32'd0);
    check("rst_wrsel", 32'(bus.vram_wrsel), 32'd0);
    check("rst_rdv", 32'({bus.cpu_rdvalid, bus.dma_rdvalid}), 32'd0);
    tick();
    idle();
    reset = 1'b1;
    tick();
    tick();

    // CPU read alone
    cpu_set(13'h0123, 32'h0, 1'b0);
    #2;
    check("c_rd_ack", 32'(bus.cpu_ack), 32'd1);
    check("c_rd_dack", 32'(bus.dma_ack), 32'd0);
    tick();
    idle();
    #2;
    check("c_rd_addr", 32'(bus.vram_addr), 32'h0123);
    check("c_rd_wren", 32'(bus.vram_wren), 32'd0);
    check("c_rd_rdv1", 32'(bus.cpu_rdvalid), 32'd0);
    tick();
    #2;
    check("c_rd_rdv", 32'(bus.cpu_rdvalid), 32'd1);
    check("c_rd_data", bus.cpu_rddata, 32'hDEAD0123);
    check("c_rd_drdv", 32'(bus.dma_rdvalid), 32'd0);
    tick();
    #2;
    check("c_rd_rdv3", 32'(bus.cpu_rdvalid), 32'd0);

    // DMA write alone
    tick();
    dma_set(13'h1FFF, 32'h12345678, 8'hFF, 1'b1);
    #2;
    check("d_wr_ack", 32'(bus.dma_ack), 32'd1);
    check("d_wr_cack", 32'(bus.cpu_ack), 32'd0);
    tick();
    idle();
    #2;
    check("d_wr_wren", 32'(bus.vram_wren), 32'd1);
    check("d_wr_addr", 32'(bus.vram_addr), 32'h1FFF);
    check("d_wr_data", bus.vram_wrdata, 32'h12345678);
    check("d_wr_sel", 32'(bus.vram_wrsel), 32'hFF);
    tick();
    #2;
    check("d_wr_wren2", 32'(bus.vram_wren), 32'd0);
    check("d_wr_rdv",
          32'({bus.cpu_rdvalid, bus.dma_rdvalid}), 32'd0);
    check("d_wr_hold", 32'(bus.vram_addr), 32'h1FFF);

    // contention: CPU x4 then DMA, period 5
    tick();
    cpu_set(13'h0010, 32'h0, 1'b0);
    dma_set(13'h0020, 32'h0, 8'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      #2;
      check($sformatf("ct_cack%0d", i), 32'(bus.cpu_ack),
            32'((i % 5) != 4));
      check($sformatf("ct_dack%0d", i), 32'(bus.dma_ack),
            32'((i % 5) == 4));
      tick();
    end
    idle();
    repeat (3) tick();

    // vblank gating with CPU competing
    bus.dma_vblank_only = 1'b1;
    bus.vblank = 1'b0;
    dma_set(13'h0030, 32'h0, 8'h0, 1'b0);
    bus.cpu_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #2;
      check($sformatf("vb_dack%0d", i), 32'(bus.dma_ack), 32'd0);
      tick();
    end
    bus.vblank = 1'b1;
    #2;
    check("vb_cpu_first", 32'(bus.cpu_ack), 32'd1);
    check("vb_dma_first", 32'(bus.dma_ack), 32'd0);
    tick();
    bus.cpu_req = 1'b0;
    #2;
    check("vb_dma_go", 32'(bus.dma_ack), 32'd1);
    tick();
    bus.vblank = 1'b0;
    #2;
    check("vb_fall", 32'(bus.dma_ack), 32'd0);
    tick();
    idle();
    bus.dma_vblank_only = 1'b0;
    repeat (3) tick();

    // interleaved reads
    cpu_set(13'h0AAA, 32'h0, 1'b0);
    #2;
    check("il_cack", 32'(bus.cpu_ack), 32'd1);
    tick();
    idle();
    dma_set(13'h0555, 32'h0, 8'h0, 1'b0);
    #2;
    check("il_dack", 32'(bus.dma_ack), 32'd1);
    tick();
    idle();
    #2;
    check("il_crdv", 32'(bus.cpu_rdvalid), 32'd1);
    check("il_cdata", bus.cpu_rddata, 32'hDEAD0AAA);
    check("il_drdv0", 32'(bus.dma_rdvalid), 32'd0);
    tick();
    #2;
    check("il_drdv", 32'(bus.dma_rdvalid), 32'd1);
    check("il_ddata", bus.dma_rddata, 32'hDEAD0555);
    check("il_crdv0", 32'(bus.cpu_rdvalid), 32'd0);
    repeat (2) tick();

    // reset mid-read
    cpu_set(13'h0042, 32'h0, 1'b0);
    #2;
    check("mr_ack", 32'(bus.cpu_ack), 32'd1);
    tick();
    idle();
    reset = 1'b0;
    #2;
    check("mr_addr", 32'(bus.vram_addr), 32'd0);
    check("mr_wren", 32'(bus.vram_wren), 32'd0);
    check("mr_rdv", 32'(bus.cpu_rdvalid), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      check($sformatf("mr_post%0d", i),
            32'({bus.cpu_rdvalid, bus.cpu_ack}), 32'd0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
